// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared constants and types for the instruction fetch stage.
//   FETCH_NOP       - instruction presented to decode when nothing is queued
//   FETCH_RESET_PC  - default PC after reset
//   FETCH_ENTRY_W   - width of one queue entry {pc, instr}
//   QDEPTH          - instruction queue depth (fixed)
package cpu_fetch_pkg;

  localparam logic [31:0] FETCH_NOP      = 32'h0000_0000;
  localparam logic [31:0] FETCH_RESET_PC = 32'hFFFF_0000;
  localparam int unsigned FETCH_ENTRY_W  = 64;
  localparam int unsigned QDEPTH         = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: 2-entry FIFO holding fetched {pc, instr} words.
// Ports:
//   clock, reset      - clock, asynchronous active-low reset
//   flush             - empty the queue; wins over push
//   push, push_data   - write one entry
//   pop               - drop the head entry (ignored when empty)
//   count             - number of valid entries, 0..2
//   head              - oldest entry (undefined when count==0)
module cpu_fetch_queue
  import cpu_fetch_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [FETCH_ENTRY_W-1:0] push_data,
  input  logic                     pop,
  output logic [1:0]               count,
  output logic [FETCH_ENTRY_W-1:0] head
);

  localparam logic [1:0] FULL = 2'(QDEPTH);

  logic [FETCH_ENTRY_W-1:0] mem [QDEPTH];
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(do_push && !do_pop && count == FULL));

endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction fetch stage feeding cpu_decoder.
// Issues word requests at pc, buffers responses in a 2-entry queue, presents
// the head as p2_instr/p2_pc, and redirects on taken p3 jumps.
// Ports:
//   clock, reset                - clock, asynchronous active-low reset
//   stall, p2_pipeline_bubble   - decode hold controls
//   p3_jump, p3_jump_target     - taken control transfer and its target
//   imem_req/addr/ack           - request handshake (accept = req && ack)
//   imem_rvalid/rdata           - response, one cycle after accept
//   p2_instr, p2_pc             - instruction to decode (NOP / 0 when empty)
// Optional (macro FETCH_PERF_EN):
//   perf_fetch_empty            - cycles with empty queue and no stall
//   perf_redirects              - number of redirects
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_pipeline_bubble,
  input  logic        p3_jump,
  input  logic [31:0] p3_jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_empty,
  output logic [31:0] perf_redirects
`endif
);

  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         outstanding;
  logic         epoch;
  logic         inflight_epoch;
  logic         redirect;
  logic         pop;
  logic         push;
  logic         accept;
  logic [2:0]   occupancy;
  logic [1:0]   count;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign redirect  = p3_jump && !stall;
  assign pop       = (count != 2'd0) && !stall && !p2_pipeline_bubble;
  // Slots already claimed after this cycle's pop; a new request needs one free.
  assign occupancy = {1'b0, count} + {2'b0, outstanding} - {2'b0, pop};
  assign imem_req  = reset && !redirect && (occupancy < 3'd2);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack;
  // A response in the redirect cycle belongs to the old path even though the
  // epoch has not toggled yet.
  assign push      = imem_rvalid && outstanding && (inflight_epoch == epoch) && !redirect;

  assign push_entry.pc    = inflight_pc;
  assign push_entry.instr = imem_rdata;

  assign p2_instr = (count != 2'd0) ? head_entry.instr : FETCH_NOP;
  assign p2_pc    = (count != 2'd0) ? head_entry.pc    : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc             <= word_align(RESET_PC);
      inflight_pc    <= '0;
      outstanding    <= 1'b0;
      epoch          <= 1'b0;
      inflight_epoch <= 1'b0;
    end else begin
      if (redirect) begin
        pc    <= word_align(p3_jump_target);
        epoch <= ~epoch;
      end else if (accept) begin
        pc <= pc + 32'd4;
      end
      if (accept) begin
        inflight_pc    <= pc;
        inflight_epoch <= epoch;
      end
      outstanding <= accept ? 1'b1 : (imem_rvalid ? 1'b0 : outstanding);
    end
  end

  cpu_fetch_queue u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head_entry)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetch_empty <= '0;
      perf_redirects   <= '0;
    end else begin
      if (count == 2'd0 && !stall) perf_fetch_empty <= perf_fetch_empty + 32'd1;
      if (redirect)                perf_redirects   <= perf_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed, table-driven bench for cpu_fetch.
// Memory model answers every accept one cycle later with addr ^ 32'hA5A5A5A5.
module tb_cpu_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        p2_pipeline_bubble = 1'b0;
  logic        p3_jump = 1'b0;
  logic [31:0] p3_jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_empty;
  logic [31:0] perf_redirects;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  cpu_fetch #(.RESET_PC(32'hFFFF_0000)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .p2_pipeline_bubble (p2_pipeline_bubble),
    .p3_jump            (p3_jump),
    .p3_jump_target     (p3_jump_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ack           (imem_ack),
    .imem_rvalid        (imem_rvalid),
    .imem_rdata         (imem_rdata),
    .p2_instr           (p2_instr),
    .p2_pc              (p2_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_empty   (perf_fetch_empty),
    .perf_redirects     (perf_redirects)
`endif
  );

  // Memory: not reset, so a response in flight at reset time still arrives.
  always @(posedge clock) begin
    imem_rvalid <= imem_req && imem_ack;
    imem_rdata  <= imem_addr ^ KEY;
  end

  typedef struct {
    logic        stall;
    logic        bubble;
    logic        jump;
    logic [31:0] target;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic s, input logic b, input logic j, input logic [31:0] t,
                   input logic a, input logic er, input logic [31:0] ea,
                   input logic ev, input logic [31:0] ep);
    vec_t x;
    x.stall = s; x.bubble = b; x.jump = j; x.target = t; x.ack = a;
    x.exp_req = er; x.exp_addr = ea; x.exp_valid = ev; x.exp_pc = ep;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;

    // stall bub jmp target        ack req addr          valid pc
    // steady fetch from reset
    v(0,0,0,32'h0,1, 1,32'hFFFF0000, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFF0004, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFF0008, 1,32'hFFFF0000);
    v(0,0,0,32'h0,1, 1,32'hFFFF000C, 1,32'hFFFF0004);
    v(0,0,0,32'h0,1, 1,32'hFFFF0010, 1,32'hFFFF0008);
    // decoder bubble for 4 cycles
    for (int i = 0; i < 4; i++) v(0,1,0,32'h0,1, 0,32'hFFFF0014, 1,32'hFFFF000C);
    v(0,0,0,32'h0,1, 1,32'hFFFF0014, 1,32'hFFFF000C);
    v(0,0,0,32'h0,1, 1,32'hFFFF0018, 1,32'hFFFF0010);
    v(0,0,0,32'h0,1, 1,32'hFFFF001C, 1,32'hFFFF0014);
    v(0,0,0,32'h0,1, 1,32'hFFFF0020, 1,32'hFFFF0018);
    // ack withheld for 5 cycles
    v(0,0,0,32'h0,0, 1,32'hFFFF0024, 1,32'hFFFF001C);
    v(0,0,0,32'h0,0, 1,32'hFFFF0024, 1,32'hFFFF0020);
    for (int i = 0; i < 3; i++) v(0,0,0,32'h0,0, 1,32'hFFFF0024, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFF0024, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFF0028, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFF002C, 1,32'hFFFF0024);
    // jump with a response in flight, misaligned target
    v(0,0,1,32'h00001002,1, 0,32'hFFFF0030, 1,32'hFFFF0028);
    v(0,0,0,32'h0,1, 1,32'h00001000, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'h00001004, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'h00001008, 1,32'h00001000);
    // jump held under stall, taken when stall drops
    for (int i = 0; i < 3; i++) v(1,0,1,32'h00002000,1, 0,32'h0000100C, 1,32'h00001004);
    v(0,0,1,32'h00002000,1, 0,32'h0000100C, 1,32'h00001004);
    v(0,0,0,32'h0,1, 1,32'h00002000, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'h00002004, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'h00002008, 1,32'h00002000);
    // jump near the top of memory: pc wraps to 0
    v(0,0,1,32'hFFFFFFF8,1, 0,32'h0000200C, 1,32'h00002004);
    v(0,0,0,32'h0,1, 1,32'hFFFFFFF8, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'hFFFFFFFC, 0,32'h0);
    v(0,0,0,32'h0,1, 1,32'h00000000, 1,32'hFFFFFFF8);
    v(0,0,0,32'h0,1, 1,32'h00000004, 1,32'hFFFFFFFC);
    v(0,0,0,32'h0,1, 1,32'h00000008, 1,32'h00000000);

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("reset req", {31'b0, imem_req}, 32'h0);
    check("reset instr", p2_instr, 32'h0);
    check("reset pc", p2_pc, 32'h0);

    @(negedge clock);
    reset = 1'b1;
    foreach (vecs[i]) begin
      stall = vecs[i].stall;
      p2_pipeline_bubble = vecs[i].bubble;
      p3_jump = vecs[i].jump;
      p3_jump_target = vecs[i].target;
      imem_ack = vecs[i].ack;
      #1;
      exp_instr = vecs[i].exp_valid ? (vecs[i].exp_pc ^ KEY) : 32'h0;
      exp_pc    = vecs[i].exp_valid ? vecs[i].exp_pc : 32'h0;
      check($sformatf("c%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("c%0d addr", i), imem_addr, vecs[i].exp_addr);
      check($sformatf("c%0d instr", i), p2_instr, exp_instr);
      check($sformatf("c%0d pc", i), p2_pc, exp_pc);
      @(negedge clock);
    end

    // reset mid-stream: a request was accepted on the last edge
    stall = 1'b0; p2_pipeline_bubble = 1'b0; p3_jump = 1'b0; imem_ack = 1'b1;
    #1;
`ifdef FETCH_PERF_EN
    check("perf empty before reset", perf_fetch_empty, 32'd13);
    check("perf redirects before reset", perf_redirects, 32'd3);
`endif
    check("stale rvalid present", {31'b0, imem_rvalid}, 32'h1);
    reset = 1'b0;
    #1;
    check("midreset req", {31'b0, imem_req}, 32'h0);
    check("midreset instr", p2_instr, 32'h0);
    check("midreset pc", p2_pc, 32'h0);
    check("midreset addr", imem_addr, 32'hFFFF0000);
`ifdef FETCH_PERF_EN
    check("perf empty reset", perf_fetch_empty, 32'd0);
    check("perf redirects reset", perf_redirects, 32'd0);
`endif
    #1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("restart addr", imem_addr, 32'hFFFF0004);
    check("stale dropped instr", p2_instr, 32'h0);
    check("stale dropped pc", p2_pc, 32'h0);
`ifdef FETCH_PERF_EN
    check("perf empty 1", perf_fetch_empty, 32'd1);
`endif
    @(negedge clock);
    #1;
    check("restart first pc", p2_pc, 32'hFFFF0000);
    check("restart first instr", p2_instr, 32'hFFFF0000 ^ KEY);
    check("restart addr 2", imem_addr, 32'hFFFF0008);
`ifdef FETCH_PERF_EN
    check("perf empty 2", perf_fetch_empty, 32'd2);
    check("perf redirects 0", perf_redirects, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
Instruction fetch stage; produces p2_instr/p2_pc for cpu_decoder and consumes its p2_pipeline_bubble, stall and p3_jump feedback.
- Holds the fetch PC and issues word requests to the instruction memory/icache port.
- Buffers returned words in a 2-entry queue so held decode cycles never lose data.
- Redirects on taken jumps and discards wrong-path responses.

Parameters:
RESET_PC, 32'hFFFF0000, PC loaded on reset; bits[1:0] must be 0.
QDEPTH, 2, instruction queue entries; fixed at 2, not to be overridden.

Ports:
clock  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  global pipeline stall; same signal as decoder stall.
p2_pipeline_bubble  input  1  decoder is holding the current p2 instruction.
p3_jump  input  1  taken control transfer in p3.
p3_jump_target  input  32  redirect address; bits[1:0] ignored (forced 0).
imem_req  output  1  request valid.
imem_addr  output  32  word address of request (bits[1:0]=0).
imem_ack  input  1  memory accepts request this cycle (req && ack = accept).
imem_rvalid  input  1  response valid; exactly one cycle after each accept.
imem_rdata  input  32  response word.
p2_instr  output  32  instruction to decoder; FETCH_NOP when queue empty.
p2_pc  output  32  address of p2_instr; 0 when queue empty.

Behaviour:
Reset:
- Async while reset=0: pc=RESET_PC, queue empty, outstanding=0, epoch=0.
- Outputs during reset: imem_req=0, p2_instr=FETCH_NOP (32'h0), p2_pc=0.

State:
- pc, a 32-bit register.
- outstanding, 0/1.
- epoch, 1-bit, tagging the in-flight request.
- queue: 2 entries of {instr, pc}, plus a count of 0..2.

Pop and issue:
- pop = (count!=0) && !stall && !p2_pipeline_bubble. The head leaves the queue and the next entry, or NOP, appears the following cycle.
- imem_req = !redirect && (count + outstanding - pop) < 2. This sustains one instruction per cycle at steady state.
- imem_addr = pc. On accept: pc += 4, outstanding=1, record epoch.
- A request is held (pc unchanged) while ack=0. Wrap-around: 32'hFFFFFFFC + 4 = 0.

Response:
- A response with matching epoch is pushed to the queue with its pc.
- A response with stale epoch is dropped.
- A push and a pop in the same cycle are both performed; count is unchanged.

Redirect:
- redirect = p3_jump && !stall. It takes effect once per jump because p3 is frozen while stall is high.
- On redirect: queue flushed (count=0), epoch toggled, pc=target & ~3, imem_req=0 that cycle.
- The next cycle requests the target.
- A response arriving in the redirect cycle is dropped.
- While p3_jump=1 and stall=1: no flush; fetching continues normally.

Latency and ordering:
- Accept in cycle N, data at N+1, visible on p2_instr at N+2.
- Jump-to-target first p2_instr: 3 cycles after redirect with ack=1.
- Queue is never pushed when count=2; an overflow is an assertion failure in simulation.
- Reset mid-transfer: any in-flight response after reset release is ignored (outstanding=0).

Optional Feature:
FETCH_PERF_EN. When defined, adds two output ports:
- perf_fetch_empty (32-bit): counts cycles with count=0 and !stall.
- perf_redirects (32-bit): counts redirects.
Both reset to 0 and wrap at 2^32. When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Shared package/include (f32.vh family) holds:
- FETCH_NOP = 32'h0000_0000 (decodes as op 0).
- the RESET_PC default.
- a queue-entry width constant of 64.

One sub-module, cpu_fetch_queue:
- 2-entry FIFO with push/pop/flush, count, head outputs.
- Simultaneous push+pop supported.
- flush has priority over push.

Test Plan:
1. Reset release, ack=1 always, rdata=addr^32'hA5A5A5A5 -> imem_addr FFFF0000, FFFF0004, ... each cycle. p2_instr first valid 2 cycles after first accept with p2_pc=FFFF0000; one instruction/cycle thereafter.
2. Hold p2_pipeline_bubble=1 for 4 cycles at steady state -> p2_instr/p2_pc frozen, count reaches 2, imem_req drops. After release, sequence resumes with no gap, loss or duplicate.
3. p3_jump=1, target=32'h00001002 while a response is in flight -> in-flight word dropped, queue flushed. Next imem_addr=00001000; first p2_pc=00001000 three cycles later.
4. p3_jump=1 with stall=1 for 3 cycles, then stall=0 -> single redirect on the stall=0 cycle; epoch toggles once; no flush earlier.
5. imem_ack held 0 for 5 cycles -> imem_req and imem_addr stable; p2_instr becomes FETCH_NOP once the queue drains; fetch resumes correctly after ack=1.
6. Assert reset (0) mid-stream with a request accepted -> outputs immediately at reset values. After release, fetch restarts at RESET_PC and a stale rvalid is ignored. With FETCH_PERF_EN: counters read 0 after reset and increment as specified.
